// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-counter
// width and the byte-address to word-offset mapping.
package dmem_pkg;

    localparam int unsigned WCNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array with per-byte write enables and a
// registered read port (read-before-write on the same word).
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-bus responder: accepts one request at a time, inserts WAIT_CYCLES wait
// states, commits/reads the array on the edge entering RESP and holds the response.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [WCNT_W-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        state;
    logic [WCNT_W-1:0] wait_cnt;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;

    logic        accept;
    logic        enter_resp;
    logic        fault;
    logic        rsp_err_q;
    logic        rsp_load_q;
    logic        mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_rdata;

    // With zero wait states the array is accessed on the accept edge itself,
    // so the live request fields feed the decode while in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign accept     = (state == ST_IDLE) && req_valid;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (wait_cnt == '0));

    assign fault = (cur_addr[1:0] != 2'b00)
                || ({1'b0, cur_addr} < {1'b0, BASE_ADDR})
                || ({1'b0, cur_addr} >= LIMIT);

    assign mem_en   = enter_resp && !fault && !rst;
    assign mem_addr = AW'(word_offset(cur_addr, BASE_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WCNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_resp) begin
                rsp_err_q  <= fault;
                rsp_load_q <= !cur_we && !fault;
            end else if ((state == ST_RESP) && rsp_ready) begin
                rsp_err_q  <= 1'b0;
                rsp_load_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (cur_we),
        .be    (cur_be),
        .addr  (mem_addr),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Array read data only changes on enabled edges, so it is stable through RESP.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_load_q ? mem_rdata : '0;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp: a WAIT_CYCLES=2 instance for
// function/fault/reset scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_resp;

    logic        clk;
    logic        rst;

    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_we0, rsp_ready0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_be0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_resp #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'h0000_1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    dmem_resp #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_1000)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_we    (req_we0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_be    (req_be0),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0),
        .rsp_ready (rsp_ready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request from a negedge; returns #1 after the accept edge with
    // the request inputs scrambled so only the latched copy can matter.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = ~wdata;
        req_be    = ~be;
    endtask

    // Count negedges after the accept edge until rsp_valid; -1 if it never comes.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        issue(we, addr, wdata, be);
        wait_rsp(lat);
        rdata = rsp_rdata;
        err   = rsp_err;
        if (lat > 0) consume();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready0: got %b expected 1", req_ready0); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 00000000", rd); end
        access(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d expected 3", lat); end
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h0000_1000, 32'h0000_0055, 4'b0001, rd, er, lat);
        access(1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD_BE55) begin n_fail++; $display("FAIL be_byte0: got %h expected deadbe55", rd); end
        access(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        n_checks++; if (er !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL be_zero_rsp: got err=%b lat=%0d expected err=0 lat=3", er, lat); end
        access(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD_BE55) begin n_fail++; $display("FAIL be_zero_nochange: got %h expected deadbe55", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] fa [3] = '{32'h0000_1002, 32'h0000_0FFC, 32'h0000_2000};
        for (int i = 0; i < 3; i++) begin
            access(1'b0, fa[i], 32'h0, 4'hF, rd, er, lat);
            n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL fault_load_%h: got err=%b rdata=%h expected err=1 rdata=00000000", fa[i], er, rd); end
        end
        access(1'b1, 32'h0000_1FFC, 32'h0BEE_F00D, 4'hF, rd, er, lat);
        access(1'b0, 32'h0000_1FFC, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (er !== 1'b0 || rd !== 32'h0BEE_F00D) begin n_fail++; $display("FAIL last_word: got err=%b rdata=%h expected err=0 rdata=0beef00d", er, rd); end
        access(1'b1, 32'h0000_1002, 32'h0000_0000, 4'hF, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL fault_store_rsp: got err=%b rdata=%h expected err=1 rdata=00000000", er, rd); end
        access(1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD_BE55) begin n_fail++; $display("FAIL fault_store_nochange: got %h expected deadbe55", rd); end
    endtask

    task automatic test_hold();
        logic [31:0] rd; logic er; int lat;
        issue(1'b0, 32'h0000_1000, 32'h0, 4'hF);
        wait_rsp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL hold_latency: got %0d expected 3", lat); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1000; req_wdata = 32'h0; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_%0d: got %b expected 1", i, rsp_valid); end
            n_checks++; if (rsp_rdata !== 32'hDEAD_BE55) begin n_fail++; $display("FAIL hold_rdata_%0d: got %h expected deadbe55", i, rsp_rdata); end
            n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL hold_err_%0d: got %b expected 0", i, rsp_err); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready_%0d: got %b expected 0", i, req_ready); end
        end
        req_valid = 1'b0;
        consume();
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid); end
        access(1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD_BE55) begin n_fail++; $display("FAIL hold_no_accept: got %h expected deadbe55", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat; int seen;
        access(1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        issue(1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_rst_state: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL wait_rst_no_rsp: got %0d valid cycles expected 0", seen); end
        access(1'b0, 32'h0000_1004, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_rst_no_write: got %h expected cafef00d", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h0000_1008, 32'h0BAD_F00D, 4'hF);
        wait_rsp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL resp_rst_latency: got %0d expected 3", lat); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL resp_rst_drop: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
        access(1'b0, 32'h0000_1008, 32'h0, 4'hF, rd, er, lat);
        n_checks++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL resp_rst_kept: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic        op_we [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] op_ad [7] = '{32'h1000, 32'h1004, 32'h1000, 32'h1004, 32'h1000, 32'h1000, 32'h0FFF};
        logic [31:0] op_wd [7] = '{32'hA1B2_C3D4, 32'h1122_3344, 32'h0, 32'h0, 32'h5566_7788, 32'h0, 32'h0};
        logic [3:0]  op_be [7] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'b1100, 4'hF, 4'hF};
        logic [31:0] ex_rd [7] = '{32'h0, 32'h0, 32'hA1B2_C3D4, 32'h1122_3344, 32'h0, 32'h5566_C3D4, 32'h0};
        logic        ex_er [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d: got ready=%b valid=%b expected ready=1 valid=0", i, req_ready0, rsp_valid0); end
            req_valid0 = 1'b1;
            req_we0    = op_we[i];
            req_addr0  = op_ad[i];
            req_wdata0 = op_wd[i];
            req_be0    = op_be[i];
            @(negedge clk);
            n_checks++; if (rsp_valid0 !== 1'b1 || req_ready0 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_%0d: got valid=%b ready=%b expected valid=1 ready=0", i, rsp_valid0, req_ready0); end
            n_checks++; if (rsp_rdata0 !== ex_rd[i] || rsp_err0 !== ex_er[i]) begin n_fail++; $display("FAIL b2b_data_%0d: got rdata=%h err=%b expected rdata=%h err=%b", i, rsp_rdata0, rsp_err0, ex_rd[i], ex_er[i]); end
            if (i == 6) req_valid0 = 1'b0;
            @(negedge clk);
        end
        req_valid0 = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; req_be  = '0; rsp_ready  = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0; rsp_ready0 = 1'b1;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_faults();
        test_hold();
        test_reset_in_wait();
        test_reset_in_resp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
